instr_fetch_unit: RTL and testbench

//   Upstream fetch stage for the multi-cycle RISC-V control FSM.
//   - Owns the PC, issues reads to instruction memory over a req/rvalid handshake, and latches the returned word into the IR.
//   - Slices IR into the opcode/func3/func7/rd/rs1/rs2 fields consumed by the control unit and the decode datapath.
//   - Applies taken-branch redirects and reports fetch faults (timeout, misaligned target, bus error).

---
 rtl/instr_fetch_unit.sv | 205 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the multi-cycle RISC-V core.
// It owns the PC and the IR, and reads instruction memory over a req/rvalid handshake.
// It applies taken-branch redirects while idle.
// A timeout, a bus error or a misaligned branch target drops the unit into an absorbing FAULT state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        branch,
    input  logic        zero_flag,
    input  logic [31:0] branch_off,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fault,
    output logic [1:0]  fault_code
);

    // The counter only has to hold values up to TIMEOUT_CYC-1.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_M4 = RESET_PC - 32'd4;

    localparam logic [1:0] FC_NONE       = 2'b00;
    localparam logic [1:0] FC_TIMEOUT    = 2'b01;
    localparam logic [1:0] FC_BUS_ERR    = 2'b10;
    localparam logic [1:0] FC_MISALIGNED = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_WAIT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        next_pc;
    logic [CNT_W-1:0]   timeout_cnt;

    logic               in_flight;
    logic               complete;
    logic               complete_ok;
    logic               complete_err;
    logic               timeout_hit;
    logic               take_branch;
    logic [31:0]        branch_target;
    logic               branch_misaligned;

    // A response only counts while a read is outstanding, so a stale rvalid seen in IDLE is dropped here.
    assign in_flight         = (state == ST_REQ) || (state == ST_WAIT);
    assign complete          = in_flight && imem_rvalid;
    assign complete_ok       = complete && !imem_err;
    assign complete_err      = complete && imem_err;
    assign timeout_hit       = (state == ST_WAIT) && !imem_rvalid && (timeout_cnt == CNT_LAST);
    assign take_branch       = (state == ST_IDLE) && branch && zero_flag;
    assign branch_target     = pc + branch_off;
    assign branch_misaligned = take_branch && (branch_target[1:0] != 2'b00);

    // State register; an asynchronous reset aborts any fetch in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a misaligned redirect faults even when pc_write arrives in the same cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (branch_misaligned) begin
                    state_nxt = ST_FAULT;
                end else if (pc_write) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (complete_err) begin
                    state_nxt = ST_FAULT;
                end else if (complete_ok) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (complete_err || timeout_hit) begin
                    state_nxt = ST_FAULT;
                end else if (complete_ok) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state only, so the request is exactly one cycle long.
    always_comb begin
        imem_req   = 1'b0;
        fetch_busy = 1'b0;
        unique case (state)
            ST_REQ: begin
                imem_req   = 1'b1;
                fetch_busy = 1'b1;
            end
            ST_WAIT: begin
                fetch_busy = 1'b1;
            end
            default: begin
                imem_req   = 1'b0;
                fetch_busy = 1'b0;
            end
        endcase
    end

    // Wait counter: cleared on entry to WAIT and advanced each cycle the response is still missing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (state == ST_REQ) begin
            timeout_cnt <= '0;
        end else if ((state == ST_WAIT) && !imem_rvalid && !timeout_hit) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // PC, next-PC and IR updates. A redirect only moves next_pc, and the committed pc changes on a good completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC_M4;
            next_pc     <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if (take_branch && !branch_misaligned) begin
                next_pc <= branch_target;
            end
            if (complete_ok) begin
                instr       <= imem_rdata;
                pc          <= next_pc;
                next_pc     <= next_pc + 32'd4;
                instr_valid <= 1'b1;
            end
        end
    end

    // Sticky fault capture. At most one cause can fire per cycle because each belongs to a different state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else if (state != ST_FAULT) begin
            if (branch_misaligned) begin
                fault      <= 1'b1;
                fault_code <= FC_MISALIGNED;
            end else if (complete_err) begin
                fault      <= 1'b1;
                fault_code <= FC_BUS_ERR;
            end else if (timeout_hit) begin
                fault      <= 1'b1;
                fault_code <= FC_TIMEOUT;
            end
        end
    end

    // The address is only meaningful while imem_req is high.
    assign imem_addr = next_pc;
    assign pc_plus4  = pc + 32'd4;

    // Decode fields are plain slices of the registered IR.
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign func3  = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign func7  = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Inputs are driven 1 ns after each rising edge and outputs are sampled at the same point.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        branch;
    logic        zero_flag;
    logic [31:0] branch_off;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fault;
    logic [1:0]  fault_code;

    int errors;
    int checks;
    int busy_cnt;
    int req_cnt;
    int vld_cnt;

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_write    (pc_write),
        .branch      (branch),
        .zero_flag   (zero_flag),
        .branch_off  (branch_off),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instr       (instr),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .fetch_busy  (fetch_busy),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pw, input logic br, input logic zf,
                                 input logic [31:0] off, input logic rv,
                                 input logic [31:0] rdat, input logic er);
        pc_write    = pw;
        branch      = br;
        zero_flag   = zf;
        branch_off  = off;
        imem_rvalid = rv;
        imem_rdata  = rdat;
        imem_err    = er;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        repeat (2) tick();

        $display("[TB] reset values");
        checkOutput("rst_pc", pc, 32'hFFFF_FFFC);
        checkOutput("rst_instr", instr, 32'h0000_0013);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_fault_code", {30'd0, fault_code}, 32'd0);
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, fetch_busy}, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single fetch, rvalid in REQ");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t1_req", {31'd0, imem_req}, 32'd1);
        checkOutput("t1_addr", imem_addr, 32'd0);
        checkOutput("t1_busy", {31'd0, fetch_busy}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0050_0093, 1'b0);
        tick();
        checkOutput("t1_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("t1_instr", instr, 32'h0050_0093);
        checkOutput("t1_opcode", {25'd0, opcode}, 32'h13);
        checkOutput("t1_rd", {27'd0, rd}, 32'd1);
        checkOutput("t1_rs1", {27'd0, rs1}, 32'd0);
        checkOutput("t1_rs2", {27'd0, rs2}, 32'd5);
        checkOutput("t1_func3", {29'd0, func3}, 32'd0);
        checkOutput("t1_func7", {25'd0, func7}, 32'd0);
        checkOutput("t1_pc", pc, 32'd0);
        checkOutput("t1_pc_plus4", pc_plus4, 32'd4);
        checkOutput("t1_busy_done", {31'd0, fetch_busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t1_valid_drop", {31'd0, instr_valid}, 32'd0);
        checkOutput("t1_req_drop", {31'd0, imem_req}, 32'd0);

        $display("[TB] three fetches, response three cycles late");
        doReset();
        for (int f = 0; f < 3; f++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            tick();
            checkOutput("t2_addr", imem_addr, 32'(f * 4));
            busy_cnt = 0;
            req_cnt  = 0;
            vld_cnt  = 0;
            for (int k = 0; k < 7; k++) begin
                if (fetch_busy) busy_cnt++;
                if (imem_req) req_cnt++;
                if (instr_valid) vld_cnt++;
                applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, (k == 3), 32'h1000_0000 + 32'(f), 1'b0);
                tick();
            end
            checkOutput("t2_busy_cycles", 32'(busy_cnt), 32'd4);
            checkOutput("t2_req_cycles", 32'(req_cnt), 32'd1);
            checkOutput("t2_valid_pulses", 32'(vld_cnt), 32'd1);
            checkOutput("t2_instr", instr, 32'h1000_0000 + 32'(f));
        end
        checkOutput("t2_pc_end", pc, 32'd8);
        checkOutput("t2_pc_plus4_end", pc_plus4, 32'd12);

        $display("[TB] branch redirects");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t3_taken_addr", imem_addr, 32'd0);
        checkOutput("t3_taken_req", {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0033, 1'b0);
        tick();
        checkOutput("t3_taken_pc", pc, 32'd0);
        checkOutput("t3_taken_instr", instr, 32'h0000_0033);

        applyStimulus(1'b1, 1'b1, 1'b1, 32'd8, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t3_simul_req", {31'd0, imem_req}, 32'd1);
        checkOutput("t3_simul_addr", imem_addr, 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0020_8133, 1'b0);
        tick();
        checkOutput("t3_simul_pc", pc, 32'd8);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t3_not_taken_addr", imem_addr, 32'd12);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0213, 1'b0);
        tick();
        checkOutput("t3_busy_branch_pc", pc, 32'd12);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t3_busy_branch_ignored", imem_addr, 32'd16);

        $display("[TB] response timeout");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        repeat (16) tick();
        checkOutput("t4_no_fault_yet", {31'd0, fault}, 32'd0);
        checkOutput("t4_still_busy", {31'd0, fetch_busy}, 32'd1);
        tick();
        checkOutput("t4_fault", {31'd0, fault}, 32'd1);
        checkOutput("t4_fault_code", {30'd0, fault_code}, 32'd1);
        checkOutput("t4_busy_off", {31'd0, fetch_busy}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t4_no_req_1", {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput("t4_no_req_2", {31'd0, imem_req}, 32'd0);
        checkOutput("t4_pc_held", pc, 32'd12);

        $display("[TB] misaligned branch target");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd6, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t5_mis_fault", {31'd0, fault}, 32'd1);
        checkOutput("t5_mis_code", {30'd0, fault_code}, 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t5_mis_no_req", {31'd0, imem_req}, 32'd0);

        $display("[TB] bus error");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        checkOutput("t5_err_fault", {31'd0, fault}, 32'd1);
        checkOutput("t5_err_code", {30'd0, fault_code}, 32'd2);
        checkOutput("t5_err_instr", instr, 32'h0000_0013);
        checkOutput("t5_err_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("t5_err_pc", pc, 32'hFFFF_FFFC);

        $display("[TB] reset during WAIT, stale response");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t6_in_wait", {31'd0, fetch_busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_async_busy", {31'd0, fetch_busy}, 32'd0);
        checkOutput("t6_async_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0BAD_0093, 1'b0);
        tick();
        checkOutput("t6_stale_instr", instr, 32'h0000_0013);
        checkOutput("t6_stale_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("t6_stale_busy", {31'd0, fetch_busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t6_stale_valid_late", {31'd0, instr_valid}, 32'd0);
        checkOutput("t6_stale_pc", pc, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
        checkOutput("t6_refetch_req", {31'd0, imem_req}, 32'd1);
        checkOutput("t6_refetch_addr", imem_addr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
